// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, reset PC and bus layouts for the fetch stage
package fetch_pkg;

  localparam int BR_BUS_W       = 34;
  localparam int WS_FLUSH_BUS_W = 33;
  localparam int FS_TO_DS_BUS_W = 65;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  // fs_to_ds_bus = {inst[31:0], pc[31:0], adef}
  localparam int FS_ADEF_POS = 0;
  localparam int FS_PC_LSB   = 1;
  localparam int FS_PC_MSB   = 32;
  localparam int FS_INST_LSB = 33;
  localparam int FS_INST_MSB = 64;

  typedef struct packed {
    logic        stall;
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

  typedef struct packed {
    logic        flush;
    logic [31:0] entry;
  } ws_flush_bus_t;

endpackage

// File: rtl/fetch_queue_stage_if.sv
// rtl/fetch_queue_stage_if.sv - instruction SRAM bus and IF-to-ID handshake
interface fetch_queue_stage_if;
  import fetch_pkg::*;

  logic                      ds_allowin;
  logic                      fs_to_ds_valid;
  logic [FS_TO_DS_BUS_W-1:0] fs_to_ds_bus;

  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  modport master (
    input  ds_allowin, inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output fs_to_ds_valid, fs_to_ds_bus, inst_sram_req, inst_sram_wr, inst_sram_size,
           inst_sram_addr, inst_sram_wstrb, inst_sram_wdata
  );

  modport slave (
    output ds_allowin, inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  fs_to_ds_valid, fs_to_ds_bus, inst_sram_req, inst_sram_wr, inst_sram_size,
           inst_sram_addr, inst_sram_wstrb, inst_sram_wdata
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with clear, occupancy count and registered head
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths are legal.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full FIFO is allowed only when the head leaves in the same cycle.
  assign do_pop  = pop && (cnt_q != '0);
  assign do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_queue_stage.sv
// rtl/fetch_queue_stage.sv - LoongArch IF stage: pipelined SRAM fetch, in-flight PC queue, instruction FIFO
// Optional FETCH_ADEF_EN: misaligned fetch_pc raises an ADEF entry and halts fetch until redirect.
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter int          BUF_DEPTH       = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = fetch_pkg::RESET_PC
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [BR_BUS_W-1:0]       br_bus,
  input  logic [WS_FLUSH_BUS_W-1:0] ws_flush_bus,
  fetch_queue_stage_if.master       fs
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = ((CW > OW) ? CW : OW) + 1;

  br_bus_t       br;
  ws_flush_bus_t ws;

  logic                      redirect;
  logic [31:0]               redirect_pc;
  logic [31:0]               fetch_pc_q, fetch_pc_d;
  logic                      halted_q, halted_d;
  logic [OW-1:0]             cancel_cnt_q, cancel_cnt_d;
  logic [CW-1:0]             fifo_cnt;
  logic [OW-1:0]             outst;
  logic [SW-1:0]             inflight;
  logic                      can_issue;
  logic                      req;
  logic                      acc;
  logic                      keep_data;
  logic                      adef_push;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic [FS_TO_DS_BUS_W-1:0] fifo_wdata;
  logic [FS_TO_DS_BUS_W-1:0] fifo_head;
  logic [31:0]               pcq_head;

  assign br = br_bus;
  assign ws = ws_flush_bus;

  assign redirect    = ws.flush || (br.taken && !br.stall);
  assign redirect_pc = ws.flush ? ws.entry : br.target;

  // Buffered plus in-flight must fit in the FIFO, so every return has a slot.
  assign inflight  = SW'(fifo_cnt) + SW'(outst);
  assign can_issue = !reset && !redirect && !halted_q
                     && (outst < OW'(MAX_OUTSTANDING))
                     && (inflight < SW'(BUF_DEPTH));

`ifdef FETCH_ADEF_EN
  logic misaligned;
  assign misaligned = (fetch_pc_q[1:0] != 2'b00);
  assign req        = can_issue && !misaligned;
  // The ADEF entry waits until older requests have drained so it stays in program order.
  assign adef_push  = misaligned && !reset && !redirect && !halted_q
                      && (outst == '0) && (fifo_cnt < CW'(BUF_DEPTH));
  assign fs.inst_sram_addr = fetch_pc_q;
`else
  assign req       = can_issue;
  assign adef_push = 1'b0;
  assign fs.inst_sram_addr = {fetch_pc_q[31:2], 2'b00};
`endif

  assign acc       = req && fs.inst_sram_addr_ok;
  assign keep_data = fs.inst_sram_data_ok && (cancel_cnt_q == '0) && !redirect;
  assign fifo_push = keep_data || adef_push;
  assign fifo_pop  = fs.fs_to_ds_valid && fs.ds_allowin;

  always_comb begin
    fifo_wdata = '0;
    if (adef_push) begin
      fifo_wdata[FS_PC_MSB:FS_PC_LSB] = fetch_pc_q;
      fifo_wdata[FS_ADEF_POS]         = 1'b1;
    end else begin
      fifo_wdata[FS_INST_MSB:FS_INST_LSB] = fs.inst_sram_rdata;
      fifo_wdata[FS_PC_MSB:FS_PC_LSB]     = pcq_head;
    end
  end

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    halted_d     = halted_q;
    cancel_cnt_d = cancel_cnt_q;
    if (fs.inst_sram_data_ok && (cancel_cnt_q != '0)) begin
      cancel_cnt_d = cancel_cnt_q - 1'b1;
    end
    if (acc) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (adef_push) begin
      halted_d = 1'b1;
    end
    // Everything still in flight after this cycle belongs to the wrong path.
    if (redirect) begin
      fetch_pc_d   = redirect_pc;
      halted_d     = 1'b0;
      cancel_cnt_d = outst - OW'(fs.inst_sram_data_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q   <= RESET_PC;
      halted_q     <= 1'b0;
      cancel_cnt_q <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      halted_q     <= halted_d;
      cancel_cnt_q <= cancel_cnt_d;
    end
  end

  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_q (
    .clk       (clk),
    .reset     (reset),
    .clear     (1'b0),
    .push      (acc),
    .push_data (fetch_pc_q),
    .pop       (fs.inst_sram_data_ok),
    .head      (pcq_head),
    .count     (outst)
  );

  fetch_fifo #(
    .WIDTH (FS_TO_DS_BUS_W),
    .DEPTH (BUF_DEPTH)
  ) u_inst_q (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_cnt)
  );

  assign fs.fs_to_ds_valid  = (fifo_cnt != '0);
  assign fs.fs_to_ds_bus    = fifo_head;
  assign fs.inst_sram_req   = req;
  assign fs.inst_sram_wr    = 1'b0;
  assign fs.inst_sram_size  = 2'd2;
  assign fs.inst_sram_wstrb = 4'h0;
  assign fs.inst_sram_wdata = 32'h0;

endmodule
